// File: rtl/montgomery_row_accumulator_if.sv
// Operand/result bus between the exponentiation controller and the Montgomery core.
// The controller is the master; the multiplier core is the slave.
interface montgomery_row_accumulator_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] m_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] p_out;

    modport master (
        output start,
        output a_in,
        output b_in,
        output m_in,
        input  busy,
        input  done,
        input  p_out
    );

    modport slave (
        input  start,
        input  a_in,
        input  b_in,
        input  m_in,
        output busy,
        output done,
        output p_out
    );
endinterface

// File: rtl/montgomery_row_accumulator.sv
// Bit-serial Montgomery multiplier: P = A*B*2^-WIDTH mod M, one bit of A per cycle.
// Latency from accepted start to done is WIDTH+3 cycles; result held until the next REDUCE.
module montgomery_row_accumulator #(
    parameter int WIDTH = 8
) (
    input logic                          clk,
    input logic                          rst,
    montgomery_row_accumulator_if.slave  bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_PRECOMP = 3'd1;
    localparam logic [2:0] ST_ITER    = 3'd2;
    localparam logic [2:0] ST_REDUCE  = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    logic [2:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] m_reg;
    logic [WIDTH:0]   mb_reg;
    logic [WIDTH:0]   r_reg;
    logic [CW-1:0]    iter_cnt;
    logic [WIDTH-1:0] p_reg;

    logic             a_bit;
    logic             q_bit;
    logic [WIDTH+1:0] r_ext;
    logic [WIDTH+1:0] addend;
    logic [WIDTH:0]   r_next;
    logic             last_iter;
    logic             r_ge_m;
    logic [WIDTH-1:0] r_minus_m;
    logic [WIDTH-1:0] reduced;

    // A is consumed LSB first by shifting, so the current bit is always a_sh[0].
    always_comb begin
        a_bit     = a_sh[0];
        q_bit     = (a_bit & b_reg[0]) ^ r_reg[0];
        r_ext     = {1'b0, r_reg};
        addend    = '0;
        case ({a_bit, q_bit})
            2'b00:   addend = '0;
            2'b01:   addend = {2'b00, m_reg};
            2'b10:   addend = {2'b00, b_reg};
            default: addend = {1'b0, mb_reg};
        endcase
        r_next    = (WIDTH+1)'((r_ext + addend) >> 1);
        last_iter = (iter_cnt == CW'(WIDTH - 1));
    end

    // R < 2M holds after the loop, so one conditional subtraction fully reduces it;
    // the low WIDTH bits of the difference are exact because the result is below M.
    always_comb begin
        r_ge_m    = (r_reg >= {1'b0, m_reg});
        r_minus_m = r_reg[WIDTH-1:0] - m_reg;
        reduced   = r_ge_m ? r_minus_m : r_reg[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            a_sh     <= '0;
            b_reg    <= '0;
            m_reg    <= '0;
            mb_reg   <= '0;
            r_reg    <= '0;
            iter_cnt <= '0;
            p_reg    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        a_sh     <= bus.a_in;
                        b_reg    <= bus.b_in;
                        m_reg    <= bus.m_in;
                        r_reg    <= '0;
                        iter_cnt <= '0;
                        state    <= ST_PRECOMP;
                    end
                end
                ST_PRECOMP: begin
                    mb_reg <= {1'b0, m_reg} + {1'b0, b_reg};
                    state  <= ST_ITER;
                end
                ST_ITER: begin
                    r_reg    <= r_next;
                    a_sh     <= a_sh >> 1;
                    iter_cnt <= iter_cnt + 1'b1;
                    if (last_iter) begin
                        state <= ST_REDUCE;
                    end
                end
                ST_REDUCE: begin
                    p_reg <= reduced;
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy  = (state != ST_IDLE);
    assign bus.done  = (state == ST_DONE);
    assign bus.p_out = p_reg;

endmodule

// File: tb/tb_montgomery_row_accumulator.sv
// Directed and randomized checks of the Montgomery core against an independent
// modular-halving reference model.
module tb_montgomery_row_accumulator;

    logic clk = 1'b0;
    logic rst;
    int   compared   = 0;
    int   mismatched = 0;

    montgomery_row_accumulator_if #(.WIDTH(8)) bus ();

    montgomery_row_accumulator #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // A*B mod M followed by eight exact halvings modulo M (M odd).
    function automatic logic [7:0] mont_ref(input logic [7:0] a, input logic [7:0] b,
                                            input logic [7:0] m);
        int x;
        x = (int'(a) * int'(b)) % int'(m);
        for (int k = 0; k < 8; k++) begin
            x = (x % 2 != 0) ? (x + int'(m)) / 2 : x / 2;
        end
        return 8'(x);
    endfunction

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m,
                          output int cycles, output int busy_cycles, output logic busy_first);
        @(negedge clk);
        bus.a_in  = a;
        bus.b_in  = b;
        bus.m_in  = m;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start   = 1'b0;
        cycles      = 1;
        busy_first  = bus.busy;
        busy_cycles = bus.busy ? 1 : 0;
        while (!bus.done && cycles < 40) begin
            @(negedge clk);
            cycles++;
            if (bus.busy) busy_cycles++;
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a_in  = '0;
        bus.b_in  = '0;
        bus.m_in  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        compared++;
        if (bus.busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_busy: got %b want 0", bus.busy);
        end
        compared++;
        if (bus.done !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_done: got %b want 0", bus.done);
        end
        compared++;
        if (bus.p_out !== 8'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_p_out: got %0d want 0", bus.p_out);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int   cycles;
        int   busy_cycles;
        logic busy_first;
        run_op(8'd5, 8'd7, 8'd13, cycles, busy_cycles, busy_first);
        compared++;
        if (cycles !== 11) begin
            mismatched++;
            $display("[TB] FAIL basic_latency: got %0d want 11", cycles);
        end
        compared++;
        if (bus.p_out !== 8'd1) begin
            mismatched++;
            $display("[TB] FAIL basic_p_out: got %0d want 1", bus.p_out);
        end
        compared++;
        if (busy_first !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL basic_busy_rise: got %b want 1", busy_first);
        end
        compared++;
        if (busy_cycles !== 11) begin
            mismatched++;
            $display("[TB] FAIL basic_busy_len: got %0d want 11", busy_cycles);
        end
        @(negedge clk);
        compared++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL basic_idle_after: got busy=%b done=%b want 0/0", bus.busy, bus.done);
        end
        compared++;
        if (bus.p_out !== 8'd1) begin
            mismatched++;
            $display("[TB] FAIL basic_p_hold: got %0d want 1", bus.p_out);
        end
    endtask

    task automatic test_vectors();
        logic [7:0] va [4] = '{8'd1,   8'd0,  8'd12, 8'd254};
        logic [7:0] vb [4] = '{8'd1,   8'd9,  8'd12, 8'd254};
        logic [7:0] vm [4] = '{8'd13,  8'd13, 8'd13, 8'd255};
        logic [7:0] vp [4] = '{8'd3,   8'd0,  8'd3,  8'd1};
        int   cycles;
        int   busy_cycles;
        logic busy_first;
        for (int n = 0; n < 4; n++) begin
            run_op(va[n], vb[n], vm[n], cycles, busy_cycles, busy_first);
            compared++;
            if (bus.p_out !== vp[n] || cycles !== 11) begin
                mismatched++;
                $display("[TB] FAIL vector_%0d: got p=%0d cycles=%0d want p=%0d cycles=11",
                         n, bus.p_out, cycles, vp[n]);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        int   cycles;
        int   busy_cycles;
        logic busy_first;
        @(negedge clk);
        bus.a_in  = 8'd5;
        bus.b_in  = 8'd7;
        bus.m_in  = 8'd13;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        compared++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.p_out !== 8'd0) begin
            mismatched++;
            $display("[TB] FAIL midreset_clear: got busy=%b done=%b p=%0d want 0/0/0",
                     bus.busy, bus.done, bus.p_out);
        end
        rst = 1'b0;
        run_op(8'd1, 8'd1, 8'd13, cycles, busy_cycles, busy_first);
        compared++;
        if (bus.p_out !== 8'd3 || cycles !== 11) begin
            mismatched++;
            $display("[TB] FAIL midreset_rerun: got p=%0d cycles=%0d want p=3 cycles=11",
                     bus.p_out, cycles);
        end
    endtask

    task automatic test_ignore_mid_op();
        int guard;
        @(negedge clk);
        bus.a_in  = 8'd5;
        bus.b_in  = 8'd7;
        bus.m_in  = 8'd13;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        guard     = 1;
        repeat (3) begin
            @(negedge clk);
            guard++;
        end
        bus.a_in  = 8'd200;
        bus.b_in  = 8'd100;
        bus.m_in  = 8'd251;
        bus.start = 1'b1;
        @(negedge clk);
        guard++;
        bus.start = 1'b0;
        compared++;
        if (bus.p_out !== 8'd3) begin
            mismatched++;
            $display("[TB] FAIL ignore_p_hold: got %0d want 3", bus.p_out);
        end
        while (!bus.done && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        compared++;
        if (bus.done !== 1'b1 || guard !== 11) begin
            mismatched++;
            $display("[TB] FAIL ignore_latency: got done=%b cycles=%0d want 1/11", bus.done, guard);
        end
        compared++;
        if (bus.p_out !== 8'd1) begin
            mismatched++;
            $display("[TB] FAIL ignore_p_out: got %0d want 1", bus.p_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] m;
        logic [7:0] exp_cur;
        int         cyc = 0;
        int         last_done = 0;
        int         guard;
        @(negedge clk);
        m       = 8'($urandom_range(3, 255)) | 8'd1;
        a       = 8'($urandom_range(0, int'(m) - 1));
        b       = 8'($urandom_range(0, int'(m) - 1));
        exp_cur = mont_ref(a, b, m);
        bus.a_in  = a;
        bus.b_in  = b;
        bus.m_in  = m;
        bus.start = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            guard = 0;
            do begin
                @(negedge clk);
                cyc++;
                guard++;
            end while (!bus.done && guard < 40);
            if (!bus.done) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL b2b_timeout: op %0d got no done want done", n);
                break;
            end
            compared++;
            if (bus.p_out !== exp_cur) begin
                mismatched++;
                $display("[TB] FAIL b2b_p_out: op %0d A=%0d B=%0d M=%0d got %0d want %0d",
                         n, a, b, m, bus.p_out, exp_cur);
            end
            if (n > 0) begin
                compared++;
                if (cyc - last_done !== 12) begin
                    mismatched++;
                    $display("[TB] FAIL b2b_interval: op %0d got %0d want 12", n, cyc - last_done);
                end
            end
            last_done = cyc;
            m       = 8'($urandom_range(3, 255)) | 8'd1;
            a       = 8'($urandom_range(0, int'(m) - 1));
            b       = 8'($urandom_range(0, int'(m) - 1));
            exp_cur = mont_ref(a, b, m);
            bus.a_in = a;
            bus.b_in = b;
            bus.m_in = m;
        end
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        compared++;
        if (bus.busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL b2b_idle: got busy=%b want 0", bus.busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_reset_mid_op();
        test_ignore_mid_op();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
